// File: rtl/arm_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arm_mem_pkg                                                        |
// | Shared types and constants for the SRAM-backed ARM memory stage.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package arm_mem_pkg;

  localparam logic [31:0] c_BASE_ADDR = 32'd1024;
  localparam int          c_SRAM_DW   = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } mem_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_phase_ctr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_phase_ctr                                                     |
// | Per-half access down-counter; o_last flags the final phase cycle.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module sram_phase_ctr #(
  parameter int ACCESS_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_en,
  output logic o_last,
  output logic o_penult
);

  localparam int c_CW = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  logic [c_CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= c_CW'(ACCESS_CYCLES - 1);
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - c_CW'(1);
    end
  end

  // o_penult lets the owner register WE_N high for the hold cycle.
  assign o_last   = (r_cnt == '0);
  assign o_penult = (r_cnt == c_CW'(1));

endmodule
`default_nettype wire

// File: rtl/mem_stage_sram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_stage_sram                                                     |
// | 32-bit load/store as two 16-bit accesses to an async SRAM.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_stage_sram
  import arm_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = c_BASE_ADDR,
  parameter int          ACCESS_CYCLES = 3,
  parameter int          SRAM_AW       = 18
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  input  logic [31:0]          ALU_result,
  input  logic [31:0]          Val_Rm,
  output logic                 ready,
  output logic [31:0]          MEM_read_value,
  output logic [SRAM_AW-1:0]   SRAM_ADDR,
  input  logic [c_SRAM_DW-1:0] SRAM_DQ_in,
  output logic [c_SRAM_DW-1:0] SRAM_DQ_out,
  output logic                 SRAM_DQ_oe,
  output logic                 SRAM_WE_N
);

  mem_state_e           r_state;
  logic [SRAM_AW-1:0]   r_addr;
  logic [c_SRAM_DW-1:0] r_dq_out;
  logic                 r_oe;
  logic                 r_we_n;
  logic [c_SRAM_DW-1:0] r_rd_lo;
  logic [31:0]          r_read_value;

  logic                 w_req;
  logic                 w_rd;
  logic                 w_wr;
  logic [31:0]          w_off;
  logic [SRAM_AW-2:0]   w_widx;
  logic [SRAM_AW-1:0]   w_addr_lo;
  logic [SRAM_AW-1:0]   w_addr_hi;
  logic                 w_last;
  logic                 w_penult;
  logic                 w_ctr_start;
  logic                 w_ctr_en;

  // A simultaneous read and write resolves to a read.
  assign w_req = MEM_R_EN | MEM_W_EN;
  assign w_rd  = MEM_R_EN;
  assign w_wr  = MEM_W_EN & ~MEM_R_EN;

  assign w_off     = ALU_result - BASE_ADDR;
  assign w_widx    = (SRAM_AW-1)'(w_off >> 2);
  assign w_addr_lo = {w_widx, 1'b0};
  assign w_addr_hi = {w_widx, 1'b1};

  assign w_ctr_start = ((r_state == S_IDLE) && w_req) || ((r_state == S_LOW) && w_last);
  assign w_ctr_en    = (r_state == S_LOW) || (r_state == S_HIGH);

  sram_phase_ctr #(
    .ACCESS_CYCLES (ACCESS_CYCLES)
  ) u_phase_ctr (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_ctr_start),
    .i_en     (w_ctr_en),
    .o_last   (w_last),
    .o_penult (w_penult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_dq_out     <= '0;
      r_oe         <= 1'b0;
      r_we_n       <= 1'b1;
      r_rd_lo      <= '0;
      r_read_value <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_state  <= S_LOW;
            r_addr   <= w_addr_lo;
            r_dq_out <= Val_Rm[15:0];
            r_oe     <= w_wr;
            r_we_n   <= ~w_wr;
          end
        end
        S_LOW: begin
          if (w_last) begin
            if (w_rd) begin
              r_rd_lo <= SRAM_DQ_in;
            end
            r_state  <= S_HIGH;
            r_addr   <= w_addr_hi;
            r_dq_out <= Val_Rm[31:16];
            r_we_n   <= ~w_wr;
          end else if (w_penult) begin
            r_we_n <= 1'b1;
          end
        end
        S_HIGH: begin
          if (w_last) begin
            if (w_rd) begin
              r_read_value <= {SRAM_DQ_in, r_rd_lo};
            end
            r_state <= S_DONE;
            r_oe    <= 1'b0;
            r_we_n  <= 1'b1;
          end else if (w_penult) begin
            r_we_n <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ready          = ~w_req | (r_state == S_DONE);
  assign MEM_read_value = r_read_value;
  assign SRAM_ADDR      = r_addr;
  assign SRAM_DQ_out    = r_dq_out;
  assign SRAM_DQ_oe     = r_oe;
  assign SRAM_WE_N      = r_we_n;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_sram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_stage_sram                                                  |
// | Scoreboard bench for mem_stage_sram with a behavioural SRAM.       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MEM_R_EN = 1'b0;
  logic        MEM_W_EN = 1'b0;
  logic [31:0] ALU_result = '0;
  logic [31:0] Val_Rm = '0;
  logic        ready;
  logic [31:0] MEM_read_value;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_in;
  logic [15:0] SRAM_DQ_out;
  logic        SRAM_DQ_oe;
  logic        SRAM_WE_N;

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk            (clk),
    .rst            (rst),
    .MEM_R_EN       (MEM_R_EN),
    .MEM_W_EN       (MEM_W_EN),
    .ALU_result     (ALU_result),
    .Val_Rm         (Val_Rm),
    .ready          (ready),
    .MEM_read_value (MEM_read_value),
    .SRAM_ADDR      (SRAM_ADDR),
    .SRAM_DQ_in     (SRAM_DQ_in),
    .SRAM_DQ_out    (SRAM_DQ_out),
    .SRAM_DQ_oe     (SRAM_DQ_oe),
    .SRAM_WE_N      (SRAM_WE_N)
  );

  logic [15:0] mem [0:262143];
  assign SRAM_DQ_in = mem[SRAM_ADDR];

  always @(posedge clk) begin
    if (!SRAM_WE_N && SRAM_DQ_oe) mem[SRAM_ADDR] = SRAM_DQ_out;
  end

  typedef struct {
    logic        rd;
    logic [31:0] data;
    logic [17:0] lo;
    logic [15:0] mlo;
    logic [15:0] mhi;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: tracks the phase cycles of each access and scores it when ready rises.
  int   m_cyc = 0;
  int   m_addr_bad = 0;
  int   m_we_lows = 0;
  int   m_oe_bad = 0;
  exp_t m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_cyc = 0; m_addr_bad = 0; m_we_lows = 0; m_oe_bad = 0;
    end else if (MEM_R_EN || MEM_W_EN) begin
      if (!ready) begin
        if (q.size() > 0) begin
          if (m_cyc >= 1 && m_cyc <= 3 && SRAM_ADDR !== q[0].lo) m_addr_bad++;
          if (m_cyc >= 4 && m_cyc <= 6 && SRAM_ADDR !== (q[0].lo | 18'd1)) m_addr_bad++;
          if (m_cyc >= 1 && SRAM_DQ_oe !== !q[0].rd) m_oe_bad++;
        end
        if (m_cyc >= 1 && SRAM_WE_N === 1'b0) m_we_lows++;
        m_cyc++;
      end else begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: got completion, want none");
        end else begin
          m_e = q.pop_front();
          chk("latency", 32'(m_cyc), 32'd7);
          chk("addr_seq_errs", 32'(m_addr_bad), 32'd0);
          chk("oe_phase_errs", 32'(m_oe_bad), 32'd0);
          chk("we_low_cycles", 32'(m_we_lows), m_e.rd ? 32'd0 : 32'd4);
          chk("done_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
          chk("done_we_n", {31'd0, SRAM_WE_N}, 32'd1);
          if (m_e.rd) begin
            chk("read_value", MEM_read_value, m_e.data);
          end else begin
            chk("mem_lo", {16'd0, mem[m_e.lo]}, {16'd0, m_e.mlo});
            chk("mem_hi", {16'd0, mem[m_e.lo | 18'd1]}, {16'd0, m_e.mhi});
          end
        end
        m_cyc = 0; m_addr_bad = 0; m_we_lows = 0; m_oe_bad = 0;
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_data,
                        input logic [17:0] lo, input logic [15:0] mlo,
                        input logic [15:0] mhi);
    exp_t e;
    int   k;
    e.rd = rd; e.data = exp_data; e.lo = lo; e.mlo = mlo; e.mhi = mhi;
    q.push_back(e);
    MEM_R_EN = rd; MEM_W_EN = wr; ALU_result = a; Val_Rm = d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 20);
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL access_timeout: got ready=0 after %0d cycles, want ready=1", k);
    end
    @(posedge clk);
    #1;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1);
  end

  initial begin
    mem[2]       = 16'h1234;
    mem[3]       = 16'hABCD;
    mem[18'h3FFFE] = 16'h5A5A;
    mem[18'h3FFFF] = 16'hC3C3;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("rst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
    chk("rst_read_value", MEM_read_value, 32'd0);
    chk("rst_addr", {14'd0, SRAM_ADDR}, 32'd0);
    chk("rst_dq_out", {16'd0, SRAM_DQ_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    access(1'b1, 1'b0, 32'd1028, 32'd0, 32'hABCD1234, 18'd2, 16'd0, 16'd0);
    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'd0, 18'd4, 16'hBEEF, 16'hDEAD);
    @(negedge clk);
    chk("post_write_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
    chk("post_write_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("post_write_value_held", MEM_read_value, 32'hABCD1234);
    @(posedge clk); #1;

    // Store then load back-to-back at the base address.
    access(1'b0, 1'b1, 32'd1024, 32'h00000055, 32'd0, 18'd0, 16'h0055, 16'h0000);
    access(1'b1, 1'b0, 32'd1024, 32'd0, 32'h00000055, 18'd0, 16'd0, 16'd0);

    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, ready}, 32'd1);
      chk("idle_we_n", {31'd0, SRAM_WE_N}, 32'd1);
      chk("idle_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
      chk("idle_read_value", MEM_read_value, 32'h00000055);
    end
    @(posedge clk); #1;

    access(1'b1, 1'b1, 32'd1028, 32'hFFFFFFFF, 32'hABCD1234, 18'd2, 16'd0, 16'd0);
    chk("both_en_no_write", {16'd0, mem[2]}, 32'h00001234);
    access(1'b1, 1'b0, 32'd1030, 32'd0, 32'hABCD1234, 18'd2, 16'd0, 16'd0);
    access(1'b1, 1'b0, 32'd1020, 32'd0, 32'hC3C35A5A, 18'h3FFFE, 16'd0, 16'd0);

    // Reset in the second HIGH cycle of a write to halfwords 8/9.
    MEM_W_EN = 1'b1; ALU_result = 32'd1040; Val_Rm = 32'h11112222;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    MEM_W_EN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_state", {30'd0, dut.r_state}, 32'd0);
    chk("midrst_we_n", {31'd0, SRAM_WE_N}, 32'd1);
    chk("midrst_oe", {31'd0, SRAM_DQ_oe}, 32'd0);
    chk("midrst_read_value", MEM_read_value, 32'd0);
    chk("midrst_partial_lo", {16'd0, mem[8]}, 32'h00002222);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
